// File: rtl/param_sync_fifo_pkg.sv
// Shared constants and width helper for the single-clock FIFO and its storage.
package param_sync_fifo_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_DEPTH    = 16;
  localparam int DEF_AE_LEVEL = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  localparam int DEF_PTR_W = clog2(DEF_DEPTH);
  localparam int DEF_CNT_W = DEF_PTR_W + 1;

endpackage

// File: rtl/fifo_dp_ram.sv
// DEPTH x DATA_W storage: synchronous write; read port registered (1-cycle, reset to 0)
// or asynchronous (0-cycle) when FWFT is set.
module fifo_dp_ram
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2(DEPTH),
  parameter bit FWFT   = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (FWFT) begin : g_async_rd
      // Head of queue is always visible; pop strobe and reset have no effect here.
      logic unused_ok;
      assign unused_ok = &{1'b0, reset_n, re};
      assign rdata = mem[raddr];
    end else begin : g_reg_rd
      always_ff @(posedge clk) begin
        if (!reset_n)  rdata <= '0;
        else if (re)   rdata <= mem[raddr];
      end
    end
  endgenerate

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy flags and sticky overflow/underflow; 1-cycle read
// (0-cycle when PARAM_SYNC_FIFO_FWFT_EN is defined). Writes to a full FIFO are refused unless a read frees a slot.
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic [clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  empty,
  output logic                  half,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of 2 and at least 4");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // A full FIFO still takes a write when the same cycle pops the head.
  assign wr_ok = wr_en & (~full | rd_en);
  assign rd_ok = rd_en & ~empty;

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign half         = (count >= CNT_W'(DEPTH / 2));
  assign almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count <= CNT_W'(AE_LEVEL));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(wr_ok) - CNT_W'(rd_ok);
      if (wr_en && !wr_ok) overflow  <= 1'b1;
      if (rd_en && !rd_ok) underflow <= 1'b1;
    end
  end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  assign rd_valid = ~empty;
`else
  always_ff @(posedge clk) begin
    if (!reset_n) rd_valid <= 1'b0;
    else          rd_valid <= rd_ok;
  end
`endif

  fifo_dp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W),
    .FWFT   (FWFT)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wr_ok & reset_n),
    .waddr   (wr_ptr),
    .wdata   (wr_data),
    .re      (rd_ok),
    .raddr   (rd_ptr),
    .rdata   (rd_data)
  );

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo (DEPTH=16, DATA_W=16).
module tb_param_sync_fifo;

  localparam int DW = 16;
  localparam int DP = 16;
  localparam int AF = DP - 2;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [4:0]    count;
  logic          full, empty, half, almost_full, almost_empty, overflow, underflow;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  bit            exp_rv;
  bit            m_ov, m_uf;
  bit            mon_en;

  always #5 clk = ~clk;

  param_sync_fifo #(
    .DATA_W(DW), .DEPTH(DP), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .full(full), .empty(empty),
    .half(half), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the expected read word is queued for the monitor.
  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re);
    int n;
    bit wok, rok;
    n   = model_q.size();
    rok = re && (n != 0);
    wok = we && ((n != DP) || re);
    wr_en = we; wr_data = wd; rd_en = re;
    if (rok) exp_q.push_back(model_q.pop_front());
    if (wok) model_q.push_back(wd);
    if (we && !wok) m_ov = 1'b1;
    if (re && !rok) m_uf = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    exp_rv = rok;
  endtask

  task automatic do_reset(input bit we, input logic [DW-1:0] wd);
    reset_n = 1'b0; wr_en = we; wr_data = wd; rd_en = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; wr_en = 1'b0;
    model_q.delete();
    m_ov = 1'b0; m_uf = 1'b0; exp_rv = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ":count"},        count,        n);
    chk({tag, ":full"},         full,         n == DP);
    chk({tag, ":empty"},        empty,        n == 0);
    chk({tag, ":half"},         half,         n >= DP / 2);
    chk({tag, ":almost_full"},  almost_full,  n >= AF);
    chk({tag, ":almost_empty"}, almost_empty, n <= AE);
    chk({tag, ":overflow"},     overflow,     m_ov);
    chk({tag, ":underflow"},    underflow,    m_uf);
  endtask

  // Monitor: rd_valid must match the one-cycle-delayed accept, and every valid word is popped in order.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("rd_valid", rd_valid, exp_rv);
        if (rd_valid) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL rd_data_unexpected: got 0x%0h with nothing expected", rd_data);
          end else begin
            chk("rd_data", rd_data, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    exp_rv = 1'b0; m_ov = 1'b0; m_uf = 1'b0; mon_en = 1'b0;
    do_reset(1'b0, '0);
    do_reset(1'b0, '0);

`ifndef PARAM_SYNC_FIFO_FWFT_EN
    chk("reset:rd_data", rd_data, 0);
    chk("reset:rd_valid", rd_valid, 0);
    check_flags("reset");
    mon_en = 1'b1;

    for (int i = 1; i <= 16; i++) begin
      step(1'b1, DW'(i), 1'b0);
      check_flags($sformatf("fill%0d", i));
    end
    chk("fill:count16", count, 16);
    chk("fill:full", full, 1);

    step(1'b1, 16'hDEAD, 1'b0);
    chk("ovf:overflow", overflow, 1);
    chk("ovf:count", count, 16);

    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    check_flags("drain");

    step(1'b0, '0, 1'b1);
    chk("empty_rd:underflow", underflow, 1);
    step(1'b1, 16'hABCD, 1'b1);
    chk("wr_rd_empty:count", count, 1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    check_flags("abcd");

    do_reset(1'b0, '0);
    for (int i = 0; i < 16; i++) step(1'b1, DW'(16'h0100 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DW'(16'h0200 + i), 1'b1);
      chk($sformatf("stream%0d:count", i), count, 16);
    end
    chk("stream:overflow", overflow, 0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    check_flags("stream_drain");

    for (int i = 0; i < 9; i++) step(1'b1, DW'(16'h0300 + i), 1'b0);
    chk("pre_rst:count", count, 9);
    do_reset(1'b1, 16'hBEEF);
    check_flags("mid_rst");
    chk("mid_rst:rd_data", rd_data, 0);
    step(1'b1, 16'h5555, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    check_flags("post_rst");

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
`else
    step(1'b1, 16'h1234, 1'b0);
    chk("fwft:rd_valid", rd_valid, 1);
    chk("fwft:rd_data", rd_data, 16'h1234);
    step(1'b0, '0, 1'b0);
    chk("fwft:hold", rd_data, 16'h1234);
    step(1'b0, '0, 1'b1);
    chk("fwft:empty", empty, 1);
    chk("fwft:rd_valid_low", rd_valid, 0);
    step(1'b1, 16'h0077, 1'b1);
    chk("fwft:wr_rd_empty_count", count, 1);
    chk("fwft:wr_rd_empty_data", rd_data, 16'h0077);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
